// File: rtl/tdm_div.sv
// Time-division-multiplexed unsigned fixed-point divider: one restoring divider
// is shared across NUM_UNITS channels and all quotients are published together.
module tdm_div #(
   parameter int C_WIDTH     = 32,
   parameter int FIXED_POINT = 8,
   parameter int NUM_UNITS   = 8
) (
   input  logic                           ctl_clk,
   input  logic                           ctl_rst,
   input  logic                           start,
   input  logic [C_WIDTH*NUM_UNITS-1:0]   dividends,
   input  logic [C_WIDTH*NUM_UNITS-1:0]   divisors,
   output logic [C_WIDTH*NUM_UNITS-1:0]   quotients,
   output logic [NUM_UNITS-1:0]           div_err,
   output logic [NUM_UNITS-1:0]           ovf,
   output logic                           busy,
   output logic                           done
);

   localparam int N     = C_WIDTH + FIXED_POINT;
   localparam int CH_W  = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
   localparam int CNT_W = $clog2(N + 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ITER,
      STORE,
      PUBLISH
   } state_t;

   state_t state, state_nxt;

   logic [CH_W-1:0]              ch;
   logic [CNT_W-1:0]             cnt;

   logic [C_WIDTH*NUM_UNITS-1:0] bank_dividend;
   logic [C_WIDTH*NUM_UNITS-1:0] bank_divisor;
   logic [C_WIDTH*NUM_UNITS-1:0] work_q;
   logic [NUM_UNITS-1:0]         work_err;
   logic [NUM_UNITS-1:0]         work_ovf;

   logic [N-1:0]                 num;
   logic [N-1:0]                 q;
   logic [C_WIDTH:0]             rem;

   logic [C_WIDTH-1:0]           cur_dividend;
   logic [C_WIDTH-1:0]           cur_divisor;
   logic [C_WIDTH:0]             rem_sh;
   logic                         q_bit;
   logic [C_WIDTH:0]             rem_nxt;
   logic                         zero_div;
   logic                         last_ch;

   // Quotient saturation: a zero divisor or any integer bits beyond C_WIDTH clamp to all ones.
   function automatic logic [C_WIDTH-1:0] saturate(input logic [N-1:0] qv, input logic dz);
      if (dz || (|(qv >> C_WIDTH)))
         return '1;
      else
         return qv[C_WIDTH-1:0];
   endfunction

   function automatic logic overflowed(input logic [N-1:0] qv, input logic dz);
      return !dz && (|(qv >> C_WIDTH));
   endfunction

   always_comb begin
      cur_dividend = bank_dividend[ch*C_WIDTH +: C_WIDTH];
      cur_divisor  = bank_divisor[ch*C_WIDTH +: C_WIDTH];
      rem_sh       = {rem[C_WIDTH-1:0], num[N-1]};
      q_bit        = (rem_sh >= {1'b0, cur_divisor});
      rem_nxt      = q_bit ? (rem_sh - {1'b0, cur_divisor}) : rem_sh;
      zero_div     = (cur_divisor == '0);
      last_ch      = (ch == CH_W'(NUM_UNITS - 1));
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = LOAD;
         LOAD:    state_nxt = ITER;
         ITER:    if (cnt == CNT_W'(1)) state_nxt = STORE;
         STORE:   state_nxt = last_ch ? PUBLISH : LOAD;
         PUBLISH: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Control and output registers
   always_ff @(posedge ctl_clk) begin
      if (ctl_rst) begin
         state     <= IDLE;
         ch        <= '0;
         cnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         quotients <= '0;
         div_err   <= '0;
         ovf       <= '0;
      end else begin
         state <= state_nxt;
         done  <= (state == PUBLISH);
         case (state)
            IDLE: begin
               if (start) begin
                  ch   <= '0;
                  busy <= 1'b1;
               end
            end
            LOAD:  cnt <= CNT_W'(N);
            ITER:  cnt <= cnt - CNT_W'(1);
            STORE: if (!last_ch) ch <= ch + CH_W'(1);
            PUBLISH: begin
               quotients <= work_q;
               div_err   <= work_err;
               ovf       <= work_ovf;
               busy      <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Datapath registers: operand bank, restoring-divider state, working result bank
   always_ff @(posedge ctl_clk) begin
      case (state)
         IDLE: begin
            if (start) begin
               bank_dividend <= dividends;
               bank_divisor  <= divisors;
            end
         end
         LOAD: begin
            num <= N'(cur_dividend) << FIXED_POINT;
            rem <= '0;
            q   <= '0;
         end
         ITER: begin
            num <= num << 1;
            rem <= rem_nxt;
            q   <= {q[N-2:0], q_bit};
         end
         STORE: begin
            work_q[ch*C_WIDTH +: C_WIDTH] <= saturate(q, zero_div);
            work_err[ch]                  <= zero_div;
            work_ovf[ch]                  <= overflowed(q, zero_div);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_tdm_div.sv
// Directed bench for tdm_div: expected frames are queued at start, a monitor
// compares them whenever done pulses.
module tb_tdm_div;
   localparam int CW = 32;
   localparam int NU = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [CW*NU-1:0]  dividends = '0;
   logic [CW*NU-1:0]  divisors = '0;
   logic [CW*NU-1:0]  quotients;
   logic [NU-1:0]     div_err;
   logic [NU-1:0]     ovf;
   logic              busy;
   logic              done;

   tdm_div #(.C_WIDTH(CW), .FIXED_POINT(8), .NUM_UNITS(NU)) dut (
      .ctl_clk(clk),
      .ctl_rst(rst),
      .start(start),
      .dividends(dividends),
      .divisors(divisors),
      .quotients(quotients),
      .div_err(div_err),
      .ovf(ovf),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CW*NU-1:0] q;
      logic [NU-1:0]    err;
      logic [NU-1:0]    ovf;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          done_cnt = 0;
   logic [31:0] a[NU];
   logic [31:0] b[NU];
   logic [31:0] r[NU];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: pop and compare one expected frame per done pulse
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
               chk("unexpected_done", 256'd1, 256'd0);
            end else begin
               e = sb.pop_front();
               chk("quotients", quotients, e.q);
               chk("div_err", 256'(div_err), 256'(e.err));
               chk("ovf", 256'(ovf), 256'(e.ovf));
            end
         end
      end
   end

   task automatic set_defaults();
      for (int i = 0; i < NU; i++) begin
         a[i] = 32'h100;
         b[i] = 32'h100;
         r[i] = 32'h100;
      end
   endtask

   task automatic drive_ops();
      for (int i = 0; i < NU; i++) begin
         dividends[i*CW +: CW] = a[i];
         divisors[i*CW +: CW]  = b[i];
      end
   endtask

   function automatic exp_t make_exp(input logic [NU-1:0] err, input logic [NU-1:0] ov);
      exp_t e;
      for (int i = 0; i < NU; i++) e.q[i*CW +: CW] = r[i];
      e.err = err;
      e.ovf = ov;
      return e;
   endfunction

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!done) chk({name, "_timeout"}, 256'd0, 256'd1);
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      int   lat;
      bit   busy_ok;
      bit   hold_ok;
      int   dc;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_quotients", quotients, '0);
      chk("rst_div_err", 256'(div_err), 256'd0);
      chk("rst_ovf", 256'(ovf), 256'd0);
      chk("rst_busy", 256'(busy), 256'd0);
      chk("rst_done", 256'(done), 256'd0);

      // Frame 1: 3.0/2.0 on ch0, with latency, busy and output-hold checks
      set_defaults();
      a[0] = 32'h300; b[0] = 32'h200; r[0] = 32'h180;
      drive_ops();
      sb.push_back(make_exp('0, '0));
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat = 0;
      busy_ok = 1'b1;
      hold_ok = 1'b1;
      while (!done && lat < 2000) begin
         if (!busy) busy_ok = 1'b0;
         if (quotients !== '0) hold_ok = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", 256'(lat), 256'd337);
      chk("busy_during_frame", 256'(busy_ok), 256'd1);
      chk("outputs_held", 256'(hold_ok), 256'd1);
      @(negedge clk);
      @(negedge clk);
      chk("done_once_f1", 256'(done_cnt), 256'd1);

      // Frame 2: zero divisor on ch3
      set_defaults();
      b[3] = 32'h0; r[3] = 32'hFFFF_FFFF;
      drive_ops();
      sb.push_back(make_exp(8'h08, 8'h00));
      pulse_start();
      wait_done("f2");

      // Frame 3: saturation, truncation and assorted fixed-point ratios
      set_defaults();
      a[0] = 32'h0000_0100; b[0] = 32'h0000_0001; r[0] = 32'h0001_0000;
      a[1] = 32'h0100_0000; b[1] = 32'h0000_0001; r[1] = 32'hFFFF_FFFF;
      a[2] = 32'h0000_0001; b[2] = 32'h0000_0100; r[2] = 32'h0000_0001;
      a[4] = 32'h00FF_FFFF; b[4] = 32'h0000_0080; r[4] = 32'h01FF_FFFE;
      a[5] = 32'hFFFF_FFFF; b[5] = 32'h0000_0001; r[5] = 32'hFFFF_FFFF;
      a[6] = 32'h0000_0100; b[6] = 32'h0000_0300; r[6] = 32'h0000_0055;
      a[7] = 32'h0000_0000; b[7] = 32'h0000_0005; r[7] = 32'h0000_0000;
      drive_ops();
      sb.push_back(make_exp(8'h00, 8'h22));
      pulse_start();
      wait_done("f3");

      // Frame 4: restart request and operand changes mid-frame are ignored
      set_defaults();
      a[0] = 32'h300; b[0] = 32'h200; r[0] = 32'h180;
      drive_ops();
      sb.push_back(make_exp('0, '0));
      dc = done_cnt;
      pulse_start();
      repeat (98) @(negedge clk);
      dividends = {NU{32'h0000_1234}};
      divisors  = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("f4");
      repeat (400) @(negedge clk);
      chk("ignored_start_one_done", 256'(done_cnt - dc), 256'd1);

      // Frame 5: reset mid-frame discards the frame
      set_defaults();
      b[3] = 32'h0; r[3] = 32'hFFFF_FFFF;
      drive_ops();
      dc = done_cnt;
      pulse_start();
      repeat (148) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy", 256'(busy), 256'd0);
      chk("midrst_quotients", quotients, '0);
      chk("midrst_div_err", 256'(div_err), 256'd0);
      chk("midrst_ovf", 256'(ovf), 256'd0);
      repeat (400) @(negedge clk);
      chk("midrst_no_done", 256'(done_cnt - dc), 256'd0);

      // Frame 6: normal frame after reset
      sb.push_back(make_exp(8'h08, 8'h00));
      pulse_start();
      wait_done("f6");
      chk("scoreboard_empty", 256'(sb.size()), 256'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
